// File: rtl/my_top_level_pkg.sv
// Shared constants and the sum-fitting helper for the my_top_level adder.
// Build option: MY_TOP_LEVEL_SAT_EN selects saturating instead of wrapping results.
package my_top_level_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_LATENCY = 1;
    localparam int unsigned MAX_WIDTH       = 64;
    localparam int unsigned WIDE_W          = MAX_WIDTH + 1;

    // Reduces a carry-extended sum to 'width' result bits (wrap, or clamp when saturating).
    function automatic logic [MAX_WIDTH-1:0] fit_sum(input logic [MAX_WIDTH:0] sum_wide,
                                                     input int unsigned     width);
        logic [MAX_WIDTH:0] limit;
        limit = (WIDE_W'(1) << width) - WIDE_W'(1);
`ifdef MY_TOP_LEVEL_SAT_EN
        fit_sum = MAX_WIDTH'((sum_wide > limit) ? limit : sum_wide);
`else
        fit_sum = MAX_WIDTH'(sum_wide & limit);
`endif
    endfunction

endpackage

// File: rtl/my_top_level_if.sv
// Operand/result bundle between the adder stage and its consumer.
interface my_top_level_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] x;

    modport master (output a, output b, input  x);
    modport slave  (input  a, input  b, output x);
endinterface

// File: rtl/my_top_level_add.sv
// Combinational WIDTH+1-bit adder followed by the wrap/saturation stage.
// Build option: MY_TOP_LEVEL_SAT_EN (handled inside the package helper).
module my_top_level_add
    import my_top_level_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    my_top_level_if.slave bus
);

    logic [WIDTH:0] sum_s;

    // Carry-extended sum, then fitted back to WIDTH bits.
    always_comb begin
        sum_s  = {1'b0, bus.a} + {1'b0, bus.b};
        bus.x  = WIDTH'(fit_sum(WIDE_W'(sum_s), WIDTH));
    end

endmodule

// File: rtl/my_top_level.sv
// Pipelined unsigned adder: one operand pair per clock, result LATENCY edges later.
// Build option: MY_TOP_LEVEL_SAT_EN makes the result saturate instead of wrap.
module my_top_level
    import my_top_level_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    output logic [WIDTH-1:0] io_X
);

    my_top_level_if #(.WIDTH(WIDTH)) add_bus ();

    assign add_bus.a = io_A;
    assign add_bus.b = io_B;

    my_top_level_add #(.WIDTH(WIDTH)) u_add (
        .bus (add_bus.slave)
    );

    // Stage 0 captures the fresh sum; later stages shift it toward io_X.
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;
        logic [WIDTH-1:0] stage_q;

        if (i == 0) begin : g_head
            assign stage_d = add_bus.x;
        end else begin : g_link
            assign stage_d = g_stage[i-1].stage_q;
        end

        // Pipeline register with synchronous flush.
        always_ff @(posedge clk) begin
            if (reset) begin
                stage_q <= {WIDTH{1'b0}};
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign io_X = g_stage[LATENCY-1].stage_q;

endmodule

// File: tb/tb_my_top_level.sv
// Self-checking bench for my_top_level: LATENCY=1 and LATENCY=3 instances share stimulus.
module tb_my_top_level;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] x3;

    my_top_level_if #(.WIDTH(8)) tb_bus ();

    my_top_level #(.WIDTH(8), .LATENCY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .io_A  (tb_bus.a),
        .io_B  (tb_bus.b),
        .io_X  (tb_bus.x)
    );

    my_top_level #(.WIDTH(8), .LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .io_A  (tb_bus.a),
        .io_B  (tb_bus.b),
        .io_X  (x3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [7:0] a;
        logic [7:0] b;
    } edge_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_wrap;
        logic [7:0] exp_sat;
    } vec_t;

    edge_t hist[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic logic [7:0] ref_sum(logic [7:0] a, logic [7:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef MY_TOP_LEVEL_SAT_EN
        if (s > 255) s = 255;
`endif
        return 8'(s % 256);
    endfunction

    // Expected output after the latest edge for a pipeline of depth lat.
    function automatic logic [7:0] model_out(int lat);
        for (int k = 0; k < lat; k++) begin
            if (k >= hist.size()) return 8'h00;
            if (hist[k].r) return 8'h00;
        end
        return ref_sum(hist[lat-1].a, hist[lat-1].b);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b);
        edge_t e;
        reset    = r;
        tb_bus.a = a;
        tb_bus.b = b;
        @(posedge clk);
        e.r = r; e.a = a; e.b = b;
        hist.push_front(e);
        if (hist.size() > 16) void'(hist.pop_back());
        #1;
    endtask

    task automatic step_model(input logic r, input logic [7:0] a, input logic [7:0] b);
        step(r, a, b);
        check("model_lat1", tb_bus.x, model_out(1));
        check("model_lat3", x3, model_out(3));
    endtask

    vec_t            vecs[7];
    logic [1599:0]   stream;
    logic [7:0]      exp_v;
    logic [7:0]      pulse_exp;

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 8'h00, 8'hFF};
        vecs[1] = '{8'h03, 8'h05, 8'h08, 8'h08};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 8'hFF};
        vecs[3] = '{8'h12, 8'h34, 8'h46, 8'h46};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{8'h7F, 8'h80, 8'hFF, 8'hFF};
        vecs[6] = '{8'hFE, 8'h03, 8'h01, 8'hFF};

        reset    = 1'b1;
        tb_bus.a = 8'h12;
        tb_bus.b = 8'h34;

        // Long reset with non-zero operands: output must stay zero.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h12, 8'h34);
            check("reset_hold_lat1", tb_bus.x, 8'h00);
            check("reset_hold_lat3", x3, 8'h00);
        end
        step(1'b0, 8'h12, 8'h34);
        check("first_after_reset", tb_bus.x, 8'h46);
        check("lat3_still_zero", x3, 8'h00);
        step(1'b0, 8'h12, 8'h34);
        check("lat3_hold_zero", x3, 8'h00);
        step(1'b0, 8'h12, 8'h34);
        check("lat3_const", x3, 8'h46);

        // Directed vectors, including the wrap/saturation boundaries.
        foreach (vecs[i]) begin
`ifdef MY_TOP_LEVEL_SAT_EN
            exp_v = vecs[i].exp_sat;
`else
            exp_v = vecs[i].exp_wrap;
`endif
            step(1'b0, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), tb_bus.x, exp_v);
        end

        // Single pulse through the 3-deep pipeline.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00);
        for (int j = 0; j < 6; j++) begin
            if (j == 0) step(1'b0, 8'h10, 8'h20);
            else        step(1'b0, 8'h00, 8'h00);
            pulse_exp = (j == 2) ? 8'h30 : 8'h00;
            check($sformatf("lat3_pulse_%0d", j), x3, pulse_exp);
        end

        // Random back-to-back stream with a one-cycle reset in the middle.
        for (int w = 0; w < 50; w++) stream[w*32 +: 32] = $urandom;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                step(1'b1, 8'($urandom), 8'($urandom));
                check("mid_reset_lat1", tb_bus.x, 8'h00);
                check("mid_reset_lat3", x3, 8'h00);
            end
            step_model(1'b0, stream[i*16 +: 8], stream[i*16+8 +: 8]);
        end

        // Held inputs keep the output constant.
        for (int i = 0; i < 4; i++) step_model(1'b0, 8'hC0, 8'h41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
